// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per
// stage, operands skewed forward and resolved sum bits deskewed to the output.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  generate
    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_params
      $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
    end
  endgenerate

  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                               input logic [GROUP-1:0] b,
                                               input logic             ci);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  function automatic logic ovf_detect(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Stage k holds the effective operands, sum bits below group k, and the
  // carry into group k; group k is resolved combinationally from it.
  logic [WIDTH-1:0] a_p   [NG];
  logic [WIDTH-1:0] b_p   [NG];
  logic [WIDTH-1:0] s_p   [NG];
  logic             c_p   [NG];
  logic             vld_p [NG];
  logic [WIDTH-1:0] nxt_s [NG];
  logic             nxt_c [NG];
  logic             adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    logic [GROUP:0] res;
    res = '0;
    for (int k = 0; k < NG; k++) begin
      res      = cla_group(a_p[k][k*GROUP +: GROUP], b_p[k][k*GROUP +: GROUP], c_p[k]);
      nxt_s[k] = s_p[k];
      nxt_s[k][k*GROUP +: GROUP] = res[GROUP-1:0];
      nxt_c[k] = res[GROUP];
    end
  end

  // Stage 0 capture and stage k-1 -> k datapath transfer
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p[0] <= s1;
      b_p[0] <= sub ? ~s2 : s2;
      c_p[0] <= sub ? 1'b1 : cin;
      s_p[0] <= '0;
      for (int k = 1; k < NG; k++) begin
        a_p[k] <= a_p[k-1];
        b_p[k] <= b_p[k-1];
        s_p[k] <= nxt_s[k-1];
        c_p[k] <= nxt_c[k-1];
      end
    end
  end

  // Valid chain and output register; the whole pipe stalls on a held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NG; k++) vld_p[k] <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < NG; k++) vld_p[k] <= vld_p[k-1];
      out_valid <= vld_p[NG-1];
      if (vld_p[NG-1]) begin
        sum  <= nxt_s[NG-1];
        cout <= nxt_c[NG-1];
        ovf  <= ovf_detect(a_p[NG-1][WIDTH-1], b_p[NG-1][WIDTH-1],
                           nxt_s[NG-1][WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed corner cases, random streaming with a
// scoreboard, backpressure, and mid-flight reset on 16/4 and 8/2 instances.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] s1, s2, sum;
  logic        rst8, in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  s1_8, s2_8, sum8;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s1(s1), .s2(s2), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_cla_adder #(.WIDTH(8), .GROUP(2)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .s1(s1_8), .s2(s2_8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int nret   = 0;
  int ret_cyc[$];

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;
  res_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the effective operands.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] bs,
                                 input logic ci, input logic sb);
    logic [15:0] b;
    int unsigned u;
    int          sv;
    int          c;
    res_t        r;
    b   = sb ? ~bs : bs;
    c   = sb ? 1 : int'(ci);
    u   = int'(a) + int'(b) + c;
    sv  = int'($signed(a)) + int'($signed(b)) + c;
    r.s = u[15:0];
    r.c = u[16];
    r.o = (sv > 32767) || (sv < -32768);
    return r;
  endfunction

  // Scoreboard monitor, sampled mid-cycle where inputs and outputs are settled.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        assert (exp_q.size() > 0) passed++;
        else $error("FAIL sb_unexpected_out: observed sum 0x%0h with empty scoreboard", sum);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_sum", sum, e.s);
          check("sb_cout", cout, e.c);
          check("sb_ovf", ovf, e.o);
        end
        nret++;
        ret_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) exp_q.push_back(model(s1, s2, cin, sub));
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb, input logic [15:0] es, input logic ec,
                        input logic eo, input string tag);
    int lat;
    @(posedge clk); #1;
    s1 = a; s2 = b; cin = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec, input logic eo,
                       input string tag);
    int lat;
    @(posedge clk); #1;
    s1_8 = a; s2_8 = b; cin8 = ci; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum8, es);
    check({tag, "_cout"}, cout8, ec);
    check({tag, "_ovf"}, ovf8, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required $finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, span, pulses;
    logic acc;
    logic [17:0] held;

    rst = 1'b1; in_valid = 1'b0; s1 = '0; s2 = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    rst8 = 1'b1; in_valid8 = 1'b0; s1_8 = '0; s2_8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst8_out_valid", out_valid8, 0);
    rst = 1'b0; rst8 = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_in_ready8", in_ready8, 1);

    // Directed corner cases
    send16(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "add_basic");
    send16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "carry_all");
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    send16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
    send16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    send16(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_wrap");

    // Back-to-back random stream
    repeat (6) @(posedge clk);
    #1;
    nret = 0;
    ret_cyc.delete();
    for (int i = 0; i < 12; i++) begin
      s1 = 16'($urandom); s2 = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    w = 0;
    while (nret < 12 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check("stream_count", nret, 12);
    span = (ret_cyc.size() >= 12) ? ret_cyc[11] - ret_cyc[0] : -1;
    check("stream_consecutive", span, 11);
    check("stream_sb_empty", exp_q.size(), 0);

    // Backpressure mid-stream
    repeat (4) @(posedge clk);
    nret = 0;
    fork
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
          s1 = 16'($urandom); s2 = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
          in_valid = 1'b1;
          acc = 1'b0;
          w = 0;
          while (!acc && w < 30) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            w++;
          end
          check("bp_beat_accepted", acc, 1);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = {out_valid, sum, cout};
        held[0] = cout;
        for (int j = 0; j < 5; j++) begin
          if (j > 0) @(negedge clk);
          check("bp_in_ready_low", in_ready, 0);
          check("bp_out_valid_held", out_valid, 1);
          check("bp_output_stable", {out_valid, sum, cout}, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    w = 0;
    while (nret < 6 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check("bp_count", nret, 6);
    check("bp_sb_empty", exp_q.size(), 0);

    // Reset with beats in flight
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      s1 = 16'($urandom); s2 = 16'($urandom); cin = 1'($urandom); sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rf_pre_out_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rf_out_valid_async", out_valid, 0);
    check("rf_sum_async", sum, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("rf_no_pulse", pulses, 0);

    // 8-bit, 2-bit-group instance
    send8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "w8_carry_all");
    send8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "w8_ovf");
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      s1_8 = 8'($urandom); s2_8 = 8'($urandom); cin8 = 1'($urandom);
      in_valid8 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("w8_rf_pre_out_valid", out_valid8, 1);
    #2;
    rst8 = 1'b1;
    #1;
    check("w8_rf_out_valid_async", out_valid8, 0);
    check("w8_rf_sum_async", sum8, 0);
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid8) pulses++;
    end
    check("w8_rf_no_pulse", pulses, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
